// File: rtl/bcd_display_formatter_if.sv
// Request/result bundle between the CPU-side requester and the digit formatter.
// The master drives requests; the slave (formatter) returns the digit word and status.
interface bcd_display_formatter_if;
  logic        valid_in;
  logic [31:0] data_in;
  logic        dec_mode;
  logic [31:0] x_out;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output valid_in, data_in, dec_mode,
    input  x_out, busy, done, overflow
  );

  modport slave (
    input  valid_in, data_in, dec_mode,
    output x_out, busy, done, overflow
  );
endinterface

// File: rtl/bcd_display_formatter.sv
// Formats a 32-bit value into 8 display nibbles: hex passthrough, or a sequential
// double-dabble BCD conversion (one bit per cycle) with overflow above 99,999,999.
module bcd_display_formatter (
  input logic                      clk,
  input logic                      rst,
  bcd_display_formatter_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]  state_q;
  logic [4:0]  cnt_q;
  logic [39:0] bcd_q;
  logic [31:0] bin_q;
  logic        mode_q;
  logic [31:0] x_q;
  logic        done_q;
  logic        ovf_q;
  logic [39:0] bcd_adj;

  // Add-3 correction applied before each shift so no digit exceeds 9 afterwards.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            mode_q  <= bus.dec_mode;
            bin_q   <= bus.data_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= bus.dec_mode ? SHIFT : FINISH;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[38:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (mode_q) begin
            if (bcd_q[39:32] == 8'd0) begin
              x_q   <= bcd_q[31:0];
              ovf_q <= 1'b0;
            end else begin
              x_q   <= 32'hEEEE_EEEE;
              ovf_q <= 1'b1;
            end
          end else begin
            // Hex requests never shift, so bin_q still holds the captured value.
            x_q   <= bin_q;
            ovf_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x_out    = x_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule
